// File: rtl/sub_bytes_seq_if.sv
// Request/response channel of the sequential SubBytes engine: input state on one
// valid/ready pair, substituted state on the other.
interface sub_bytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [0:127] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [0:127] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/sub_bytes_seq.sv
// Sequential AES forward SubBytes: substitutes LANES bytes per cycle of a 128-bit
// state held in a work register, byte 0 first, then presents the result.
module sub_bytes_seq #(
  parameter int unsigned LANES = 4
) (
  input  logic            clk,
  input  logic            rst,
  sub_bytes_seq_if.slave  bus,
  output logic            busy
);

  localparam int unsigned IDX_W    = 5;
  localparam int unsigned LAST_IDX = 16 - LANES;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [0:127]       work_q, work_d;
  logic [0:127]       sub_c;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box: multiplicative inverse as x^254 (maps 0 to 0), then affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Work register with the current group of LANES bytes substituted.
  always_comb begin
    sub_c = work_q;
    for (int l = 0; l < int'(LANES); l++) begin
      sub_c[8*(int'(idx_q) + l) +: 8] = sbox(work_q[8*(int'(idx_q) + l) +: 8]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      work_q  <= work_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.in_state;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        work_d = sub_c;
        if (idx_q == IDX_W'(LAST_IDX)) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(LANES);
        end
      end
      DONE: begin
        // A new state may be taken on the same edge the result is consumed.
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            work_d  = bus.in_state;
            idx_d   = '0;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && bus.out_ready));
  assign bus.out_valid = !rst && (state_q == DONE);
  assign bus.out_state = rst ? '0 : work_q;
  assign busy          = !rst && (state_q != IDLE);

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: one instance per legal LANES value, checked against a
// FIPS-197 table model and its inverse.
module tb_sub_bytes_seq;

  localparam int NL = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_a  [NL];
  logic         iv_a   [NL];
  logic [0:127] is_a   [NL];
  logic         ordy_a [NL];
  wire          ir_a   [NL];
  wire          ov_a   [NL];
  wire  [0:127] os_a   [NL];
  wire          busy_a [NL];

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] sbox_tab [256];
  logic [7:0] inv_tab  [256];

  for (genvar g = 0; g < NL; g++) begin : g_lane
    sub_bytes_seq_if bus_if ();
    assign bus_if.in_valid  = iv_a[g];
    assign bus_if.in_state  = is_a[g];
    assign bus_if.out_ready = ordy_a[g];
    assign ir_a[g] = bus_if.in_ready;
    assign ov_a[g] = bus_if.out_valid;
    assign os_a[g] = bus_if.out_state;
    sub_bytes_seq #(.LANES(1 << g)) u_dut (
      .clk  (clk),
      .rst  (rst_a[g]),
      .bus  (bus_if),
      .busy (busy_a[g])
    );
  end

  task automatic chk(input int k, input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL L%0d/%s: got %h expected %h", 1 << k, tag, got, exp);
    end
  endtask

  function automatic int nsteps(input int k);
    return 16 >> k;
  endfunction

  function automatic logic [0:127] model_sub(input logic [0:127] x);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] model_inv(input logic [0:127] x);
    logic [0:127] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tab[x[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Single transaction from IDLE with out_ready high; returns result and checks latency.
  task automatic send_one(input int k, input logic [0:127] x, output logic [0:127] y);
    int cyc;
    bit seen;
    @(negedge clk);
    iv_a[k] = 1'b1; is_a[k] = x; ordy_a[k] = 1'b1;
    #1;
    chk(k, "idle_in_ready", ir_a[k], 1);
    @(posedge clk);
    cyc = 0;
    @(negedge clk);
    iv_a[k] = 1'b0; is_a[k] = rnd128();
    seen = 1'b0;
    y = '0;
    for (int t = 0; t < 40 && !seen; t++) begin
      if (ov_a[k]) begin
        seen = 1'b1;
        y = os_a[k];
      end else begin
        @(posedge clk); cyc++; @(negedge clk);
      end
    end
    chk(k, "result_seen", seen, 1);
    chk(k, "latency", cyc, nsteps(k));
    @(posedge clk); @(negedge clk);
    chk(k, "out_valid_drop", ov_a[k], 0);
  endtask

  // Streams src through the lane; optional random backpressure and input gaps.
  task automatic run_stream(input int k, input logic [0:127] src_in[$], input bit bp, input bit gaps);
    logic [0:127] src[$];
    logic [0:127] exp_q[$];
    int acc_q[$];
    int cyc = 0;
    int guard = 0;
    bit shown = 1'b0;
    bit took = 1'b0;
    src = src_in;
    while ((src.size() > 0 || exp_q.size() > 0) && guard < 3000) begin
      @(negedge clk);
      if (took) begin
        iv_a[k] = 1'b0; is_a[k] = rnd128(); took = 1'b0;
      end
      ordy_a[k] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!iv_a[k] && src.size() > 0 && (!gaps || $urandom_range(0, 2) != 0)) begin
        iv_a[k] = 1'b1; is_a[k] = src[0];
      end
      #1;
      if (ov_a[k] && exp_q.size() == 0) begin
        chk(k, "spurious_out_valid", ov_a[k], 0);
      end else if (ov_a[k]) begin
        if (!shown) begin
          chk(k, "stream_latency", cyc - acc_q[0], nsteps(k));
          shown = 1'b1;
        end
        chk(k, "out_state", os_a[k], model_sub(exp_q[0]));
        if (ordy_a[k]) begin
          chk(k, "round_trip", model_inv(os_a[k]), exp_q[0]);
          if (iv_a[k]) chk(k, "zero_bubble_in_ready", ir_a[k], 1);
          void'(exp_q.pop_front());
          void'(acc_q.pop_front());
          shown = 1'b0;
        end
      end
      if (iv_a[k] && ir_a[k]) begin
        exp_q.push_back(src.pop_front());
        acc_q.push_back(cyc + 1);
        took = 1'b1;
      end
      @(posedge clk);
      cyc++;
      guard++;
    end
    iv_a[k] = 1'b0;
    chk(k, "stream_drained", src.size() + exp_q.size(), 0);
  endtask

  // Hold the result for 10 cycles with out_ready low while in_state toggles.
  task automatic bp_test(input int k);
    logic [0:127] x, e;
    int cyc = 0;
    x = rnd128();
    e = model_sub(x);
    @(negedge clk);
    iv_a[k] = 1'b1; is_a[k] = x; ordy_a[k] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv_a[k] = 1'b0;
    while (!ov_a[k] && cyc < 40) begin
      @(posedge clk); cyc++; @(negedge clk);
    end
    chk(k, "bp_out_valid", ov_a[k], 1);
    for (int t = 0; t < 10; t++) begin
      iv_a[k] = 1'b1; is_a[k] = rnd128();
      #1;
      chk(k, "bp_hold_valid", ov_a[k], 1);
      chk(k, "bp_in_ready_low", ir_a[k], 0);
      chk(k, "bp_stable", os_a[k], e);
      @(posedge clk); @(negedge clk);
    end
    iv_a[k] = 1'b0; ordy_a[k] = 1'b1;
    #1;
    chk(k, "bp_release", os_a[k], e);
    @(posedge clk); @(negedge clk);
    chk(k, "bp_done_valid", ov_a[k], 0);
    chk(k, "bp_done_busy", busy_a[k], 0);
  endtask

  // Reset halfway through RUN, then a fresh 00..0f state.
  task automatic reset_test(input int k);
    logic [0:127] y;
    @(negedge clk);
    iv_a[k] = 1'b1; is_a[k] = rnd128(); ordy_a[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_a[k] = 1'b0;
    repeat (nsteps(k) / 2) @(posedge clk);
    @(negedge clk);
    chk(k, "rst_busy_before", busy_a[k], 1);
    rst_a[k] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk(k, "rst_out_valid", ov_a[k], 0);
    chk(k, "rst_busy", busy_a[k], 0);
    chk(k, "rst_in_ready", ir_a[k], 0);
    chk(k, "rst_out_state", os_a[k], 0);
    rst_a[k] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk(k, "post_rst_in_ready", ir_a[k], 1);
    send_one(k, 128'h000102030405060708090a0b0c0d0e0f, y);
    chk(k, "post_rst_result", y, 128'h637c777bf26b6fc53001672bfed7ab76);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, limit 1000000", $time);
    $fatal(1);
  end

  initial begin
    logic [0:2047] flat;
    logic [0:127]  y;
    logic [0:127]  q[$];
    logic [0:127]  st;

    flat = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox_tab[i] = flat[8*i +: 8];
    for (int i = 0; i < 256; i++) inv_tab[sbox_tab[i]] = 8'(i);

    for (int k = 0; k < NL; k++) begin
      rst_a[k] = 1'b1; iv_a[k] = 1'b0; is_a[k] = '0; ordy_a[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      chk(k, "reset_out_valid", ov_a[k], 0);
      chk(k, "reset_in_ready", ir_a[k], 0);
      chk(k, "reset_busy", busy_a[k], 0);
      chk(k, "reset_out_state", os_a[k], 0);
      rst_a[k] = 1'b0;
    end

    for (int k = 0; k < NL; k++) begin
      send_one(k, 128'h00112233445566778899aabbccddeeff, y);
      chk(k, "fips_vector", y, 128'h638293c31bfc33f5c4eeacea4bc12816);

      q.delete();
      for (int j = 0; j < 16; j++) begin
        for (int b = 0; b < 16; b++) st[8*b +: 8] = 8'(16*j + b);
        q.push_back(st);
      end
      run_stream(k, q, 1'b0, 1'b0);

      q.delete();
      for (int j = 0; j < 12; j++) q.push_back(rnd128());
      run_stream(k, q, 1'b1, 1'b1);

      bp_test(k);
      reset_test(k);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
